// File: rtl/cpu_mul_sequencer.sv
// rtl/cpu_mul_sequencer.sv - multi-cycle unsigned shift-add multiply controller with pipeline stall
// Optional early exit when the remaining multiplier bits are zero: define CPU_MUL_EARLY_EXIT_EN.
`timescale 1ns/1ps
module cpu_mul_sequencer #(
  parameter int WIDTH    = 32,
  parameter int RD_WIDTH = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                flush,
  input  logic [WIDTH-1:0]    op_a,
  input  logic [WIDTH-1:0]    op_b,
  input  logic [RD_WIDTH-1:0] rd_in,
  output logic                stall,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    result_lo,
  output logic [WIDTH-1:0]    result_hi,
  output logic [RD_WIDTH-1:0] rd_out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               run_last;
  logic               accept;

  // Partial product for this step; the full product fits in 2*WIDTH bits so no carry is lost.
  assign acc_sum = mplier[0] ? (acc + mcand) : acc;

`ifdef CPU_MUL_EARLY_EXIT_EN
  assign run_last = (cnt == CNT_LAST) || ((mplier >> 1) == '0);
`else
  assign run_last = (cnt == CNT_LAST);
`endif

  assign accept = (state == ST_IDLE) && start && !flush;

  // Gated by reset so the pipeline is never held while the block is in reset.
  assign stall = reset && (accept || (state == ST_RUN));

  // Next-state selection; flush overrides everything and returns to IDLE.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) state_nxt = ST_RUN;
        ST_RUN:  if (run_last) state_nxt = ST_DONE;
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register with registered busy/done derived from the state being entered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == ST_RUN) || (state_nxt == ST_DONE);
      done  <= (state_nxt == ST_DONE);
    end
  end

  // Shift-add datapath; results are written only when a RUN completes without flush.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      rd_out    <= '0;
      result_lo <= '0;
      result_hi <= '0;
    end else if (accept) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, op_a};
      mplier <= op_b;
      cnt    <= '0;
      rd_out <= rd_in;
    end else if ((state == ST_RUN) && !flush) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (run_last) begin
        result_lo <= acc_sum[WIDTH-1:0];
        result_hi <= acc_sum[2*WIDTH-1:WIDTH];
      end
    end
  end

endmodule
